// File: rtl/design_sel_ctrl.sv
// design_sel_ctrl: sequences a design-select change for a downstream input mux.
// The selected project is held in reset while sel changes and for a guard period
// afterwards, so sel never moves while proj_rst_n is released.
module design_sel_ctrl #(
    parameter int unsigned SEL_BITS     = 5,
    parameter int unsigned NUM_DESIGNS  = 20,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    input  logic [SEL_BITS-1:0] req_sel,
    output logic                req_ready,
    input  logic                user_rst_n,
    output logic [SEL_BITS-1:0] sel,
    output logic                proj_rst_n,
    output logic                busy,
    output logic                err,
    output logic [7:0]          sw_count
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    logic [SEL_BITS-1:0] r_sel;
    logic [SEL_BITS-1:0] r_pend;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_proj_rst_n;
    logic                r_err;
    logic [7:0]          r_sw_count;
    // Set once a real switch has passed DRAIN; keeps the post-reset RUN entry uncounted.
    logic                r_sw_arm;

    logic w_in_run;
    logic w_req_fire;
    logic w_req_bad;

    assign w_in_run   = (r_state == ST_RUN);
    assign w_req_fire = req_valid && w_in_run;
    assign w_req_bad  = (32'(req_sel) >= NUM_DESIGNS);

    assign req_ready  = w_in_run;
    assign busy       = !w_in_run;
    assign sel        = r_sel;
    assign proj_rst_n = r_proj_rst_n;
    assign err        = r_err;
    assign sw_count   = r_sw_count;

    // Switch sequencer: RUN -> DRAIN -> HOLD (guard) -> RUN, with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_HOLD;
            r_sel        <= '0;
            r_pend       <= '0;
            r_cnt        <= '0;
            r_proj_rst_n <= 1'b0;
            r_err        <= 1'b0;
            r_sw_count   <= '0;
            r_sw_arm     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_req_fire && !w_req_bad) begin
                        r_state      <= ST_DRAIN;
                        r_pend       <= req_sel;
                        r_proj_rst_n <= 1'b0;
                    end else begin
                        r_err        <= w_req_fire;
                        r_proj_rst_n <= user_rst_n;
                    end
                end
                ST_DRAIN: begin
                    r_sel        <= r_pend;
                    r_state      <= ST_HOLD;
                    r_cnt        <= '0;
                    r_sw_arm     <= 1'b1;
                    r_proj_rst_n <= 1'b0;
                end
                ST_HOLD: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == GUARD_LAST) begin
                        r_state      <= ST_RUN;
                        r_proj_rst_n <= user_rst_n;
                        r_sw_arm     <= 1'b0;
                        if (r_sw_arm) begin
                            r_sw_count <= r_sw_count + 8'd1;
                        end
                    end else begin
                        r_proj_rst_n <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_HOLD;
                    r_cnt        <= '0;
                    r_proj_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule
